// File: rtl/dmem_controller_if.sv
// Data-memory request/acknowledge bus.
// Signals:
//   mem_req   - request, held high until mem_ack
//   mem_we    - 1 = write, 0 = read; valid while mem_req
//   mem_addr  - word address; valid while mem_req
//   mem_wdata - store data; valid while mem_req
//   mem_rdata - read data; sampled when mem_ack=1
//   mem_ack   - single-cycle completion pulse
// Modports: master (controller side), slave (memory side).
interface dmem_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_controller.sv
// MEM-stage data memory controller.
// Decodes DMC_MEM, runs a req/ack handshake to a variable-latency data
// memory, stalls the pipeline while an access is outstanding and returns
// load data to the WB mux.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   DMC_MEM     - 00 none, 01 load, 10 store, 11 reserved (none)
//   ADDR_MEM    - effective address
//   WDATA_MEM   - store data
//   RDATA_MEM   - load data (registered), held until next load completes
//   Mem_Stall   - pipeline freeze (combinational)
//   MisAlign    - misaligned load/store seen in IDLE (combinational)
//   Mem_Err     - sticky timeout flag
//   mem         - data-memory bus, master side
// Optional feature: define DMEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYC cycles without ack (Mem_Err set, load returns 32'hDEAD_BEEF).
module dmem_controller #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        DMC_MEM,
  input  logic [ADDR_W-1:0] ADDR_MEM,
  input  logic [DATA_W-1:0] WDATA_MEM,
  output logic [DATA_W-1:0] RDATA_MEM,
  output logic              Mem_Stall,
  output logic              MisAlign,
  output logic              Mem_Err,
  dmem_controller_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_req, w_req_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_is_acc;
  logic              w_aligned;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             w_timeout;

  // Fires on the BUSY cycle that would bring the count to TIMEOUT_CYC.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign Mem_Err   = r_err;
`else
  assign Mem_Err   = 1'b0;
`endif

  // Reserved encoding 11 is treated as no access.
  assign w_is_acc  = (DMC_MEM == 2'b01) || (DMC_MEM == 2'b10);
  assign w_aligned = (ADDR_MEM[1:0] == 2'b00);

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign RDATA_MEM     = r_rdata;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef DMEM_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
`ifdef DMEM_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  // Next-state and combinational outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    Mem_Stall   = 1'b0;
    MisAlign    = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_is_acc) begin
          if (w_aligned) begin
            Mem_Stall   = 1'b1;
            w_req_nxt   = 1'b1;
            w_we_nxt    = (DMC_MEM == 2'b10);
            w_addr_nxt  = ADDR_MEM;
            w_wdata_nxt = WDATA_MEM;
            w_state_nxt = S_BUSY;
`ifdef DMEM_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end else begin
            MisAlign = 1'b1;
          end
        end
      end
      S_BUSY: begin
        Mem_Stall = 1'b1;
        // Ack has priority over a timeout in the same cycle.
        if (mem.mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_DONE;
          if (!r_we) w_rdata_nxt = mem.mem_rdata;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
          if (!r_we) w_rdata_nxt = DATA_W'(32'hDEAD_BEEF);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      // DMC_MEM still belongs to the completed instruction here.
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: directed accesses push expected
// requests/completions into a queue; a negedge monitor pops and compares.
module tb_dmem_controller;

  logic        clk;
  logic        rst_n;
  logic [1:0]  DMC_MEM;
  logic [31:0] ADDR_MEM;
  logic [31:0] WDATA_MEM;
  logic [31:0] RDATA_MEM;
  logic        Mem_Stall;
  logic        MisAlign;
  logic        Mem_Err;

  dmem_controller_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  dmem_controller #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef DMEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .DMC_MEM   (DMC_MEM),
    .ADDR_MEM  (ADDR_MEM),
    .WDATA_MEM (WDATA_MEM),
    .RDATA_MEM (RDATA_MEM),
    .Mem_Stall (Mem_Stall),
    .MisAlign  (MisAlign),
    .Mem_Err   (Mem_Err),
    .mem       (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          stall_cnt = 0;
  logic        prev_req = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: compares each new request and each completion against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (Mem_Stall) stall_cnt++;
      if (mem_bus.mem_req && !prev_req) begin
        if (q.size() == 0) begin
          chk("unexpected_req", 32'(mem_bus.mem_req), 32'h0);
        end else begin
          cur = q[0];
          chk("req_we",    32'(mem_bus.mem_we), 32'(cur.we));
          chk("req_addr",  mem_bus.mem_addr,    cur.addr);
          chk("req_wdata", mem_bus.mem_wdata,   cur.wdata);
        end
      end
      if (!mem_bus.mem_req && prev_req) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(prev_req), 32'h0);
        end else begin
          cur = q.pop_front();
          chk("done_rdata", RDATA_MEM, cur.rdata);
          chk("done_stall_cycles", 32'(stall_cnt), 32'(cur.stall));
          chk("done_stall_low", 32'(Mem_Stall), 32'h0);
        end
        stall_cnt = 0;
      end
      prev_req = mem_bus.mem_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access acked in BUSY cycle n; DMC_MEM held through DONE.
  task automatic access(input logic [1:0] dmc, input logic [31:0] addr,
                        input logic [31:0] wdata, input int n,
                        input logic [31:0] rdata);
    exp_t e;
    if (dmc == 2'b01) exp_rdata = rdata;
    e.we = (dmc == 2'b10); e.addr = addr; e.wdata = wdata;
    e.rdata = exp_rdata; e.stall = n + 1;
    q.push_back(e);
    DMC_MEM = dmc; ADDR_MEM = addr; WDATA_MEM = wdata;
    tick();
    repeat (n - 1) tick();
    mem_bus.mem_rdata = rdata;
    mem_bus.mem_ack   = 1'b1;
    tick();
    mem_bus.mem_ack   = 1'b0;
    tick();
    DMC_MEM = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; DMC_MEM = 2'b00; ADDR_MEM = '0; WDATA_MEM = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    #12;
    chk("rst_req",   32'(mem_bus.mem_req), 32'h0);
    chk("rst_we",    32'(mem_bus.mem_we),  32'h0);
    chk("rst_addr",  mem_bus.mem_addr,     32'h0);
    chk("rst_wdata", mem_bus.mem_wdata,    32'h0);
    chk("rst_rdata", RDATA_MEM,            32'h0);
    chk("rst_err",   32'(Mem_Err),         32'h0);
    chk("rst_stall", 32'(Mem_Stall),       32'h0);
    chk("rst_misal", 32'(MisAlign),        32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Load, ack delay 1; store, ack delay 3.
    access(2'b01, 32'h100, 32'h0, 1, 32'h1234_5678);
    access(2'b10, 32'h204, 32'hCAFE_F00D, 3, 32'hFFFF_0000);

    // Misaligned load, then reserved encoding.
    DMC_MEM = 2'b01; ADDR_MEM = 32'h102;
    #1;
    chk("misal_flag",  32'(MisAlign),  32'h1);
    chk("misal_stall", 32'(Mem_Stall), 32'h0);
    tick();
    chk("misal_req",   32'(mem_bus.mem_req), 32'h0);
    DMC_MEM = 2'b11; ADDR_MEM = 32'h100;
    #1;
    chk("rsvd_flag",  32'(MisAlign),  32'h0);
    chk("rsvd_stall", 32'(Mem_Stall), 32'h0);
    tick();
    chk("rsvd_req",   32'(mem_bus.mem_req), 32'h0);
    DMC_MEM = 2'b00;
    tick();

    // Back-to-back load then store.
    access(2'b01, 32'h300, 32'h0, 2, 32'hA5A5_0001);
    access(2'b10, 32'h304, 32'h0BAD_CAFE, 1, 32'h5A5A_5A5A);

    // Stray ack in IDLE.
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    mem_bus.mem_ack   = 1'b1;
    tick();
    mem_bus.mem_ack   = 1'b0;
    chk("stray_req",   32'(mem_bus.mem_req), 32'h0);
    chk("stray_stall", 32'(Mem_Stall),       32'h0);
    chk("stray_rdata", RDATA_MEM,            exp_rdata);
    tick();

    // Reset during BUSY.
    e.we = 1'b0; e.addr = 32'h400; e.wdata = 32'h0; e.rdata = 32'h0; e.stall = 0;
    q.push_back(e);
    DMC_MEM = 2'b01; ADDR_MEM = 32'h400; WDATA_MEM = 32'h0;
    tick();
    chk("mid_req_high", 32'(mem_bus.mem_req), 32'h1);
    rst_n = 1'b0; DMC_MEM = 2'b00;
    #1;
    chk("mid_rst_req",   32'(mem_bus.mem_req), 32'h0);
    chk("mid_rst_stall", 32'(Mem_Stall),       32'h0);
    chk("mid_rst_rdata", RDATA_MEM,            32'h0);
    q.delete();
    exp_rdata = 32'h0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req",   32'(mem_bus.mem_req), 32'h0);
    chk("post_rst_stall", 32'(Mem_Stall),       32'h0);
    access(2'b01, 32'h500, 32'h0, 1, 32'h0BAD_F00D);

`ifdef DMEM_TIMEOUT_EN
    // Load with no ack: aborted after 4 BUSY cycles.
    exp_rdata = 32'hDEAD_BEEF;
    e.we = 1'b0; e.addr = 32'h600; e.wdata = 32'h0; e.rdata = exp_rdata; e.stall = 5;
    q.push_back(e);
    DMC_MEM = 2'b01; ADDR_MEM = 32'h600; WDATA_MEM = 32'h0;
    repeat (6) tick();
    DMC_MEM = 2'b00;
    chk("timeout_err", 32'(Mem_Err), 32'h1);
    access(2'b01, 32'h604, 32'h0, 2, 32'h1111_2222);
    chk("timeout_err_sticky", 32'(Mem_Err), 32'h1);
`else
    chk("no_err", 32'(Mem_Err), 32'h0);
`endif

    repeat (2) tick();
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
